gpio_in_debounce: RTL and testbench

- Input-conditioning stage between the board pins and the GPIO core's GPIO_IN port.
- Each bit passes through a synchronizer to remove metastability, then a per-bit debounce filter clocked by a shared prescaler tick.
- Outputs a clean, registered input vector plus one-cycle rise/fall event pulses for firmware or interrupt logic.
- Runs in the APB clock domain alongside the GPIO core.

---
 rtl/gpio_in_debounce.sv | 120 ++++++++++++
 tb/tb_gpio_in_debounce.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// Pin input conditioning: synchronizer, shared prescaler tick, per-bit debounce
// filter with optional bypass, and registered rise/fall/any-edge event pulses.

module gpio_db_lane #(
    parameter int   DB_COUNT = 4,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic s,
    input  logic bypass,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic edge_nxt
);
    localparam int CW = $clog2(DB_COUNT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          lvl_nxt;

    // Any sample matching the current level clears the count, so only an
    // uninterrupted run of DB_COUNT differing ticks can flip the level.
    always_comb begin
        cnt_nxt = cnt;
        lvl_nxt = lvl;
        if (bypass) begin
            cnt_nxt = '0;
            lvl_nxt = s;
        end else if (s == lvl) begin
            cnt_nxt = '0;
        end else if (tick) begin
            if (cnt == CW'(DB_COUNT - 1)) begin
                lvl_nxt = s;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    assign edge_nxt = lvl_nxt ^ lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl  <= RST_VAL;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            lvl  <= lvl_nxt;
            cnt  <= cnt_nxt;
            rise <= lvl_nxt & ~lvl;
            fall <= ~lvl_nxt & lvl;
        end
    end
endmodule

module gpio_in_debounce #(
    parameter int          IO_NUM      = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          TICK_DIV    = 16,
    parameter int          DB_COUNT    = 4,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [IO_NUM-1:0] PIN_IN,
    input  logic [IO_NUM-1:0] BYPASS,
    output logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] RISE,
    output logic [IO_NUM-1:0] FALL,
    output logic              ANY_EDGE
);
    localparam int                PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IO_NUM-1:0] RST_V = RESET_VAL[IO_NUM-1:0];

    logic [SYNC_STAGES-1:0][IO_NUM-1:0] sync_q;
    logic [PW-1:0]                      presc;
    logic                               tick;
    logic [IO_NUM-1:0]                  edge_nxt;

    // sync_q[0] takes the raw pins; the last stage is the filter input.
    always_ff @(posedge PCLK) begin
        if (PRESET) sync_q <= {SYNC_STAGES{RST_V}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], PIN_IN};
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET || tick) presc <= '0;
        else                presc <= presc + PW'(1);
    end

    for (genvar g = 0; g < IO_NUM; g++) begin : g_lane
        gpio_db_lane #(
            .DB_COUNT (DB_COUNT),
            .RST_VAL  (RST_V[g])
        ) u_lane (
            .clk      (PCLK),
            .rst      (PRESET),
            .tick     (tick),
            .s        (sync_q[SYNC_STAGES-1][g]),
            .bypass   (BYPASS[g]),
            .lvl      (GPIO_IN[g]),
            .rise     (RISE[g]),
            .fall     (FALL[g]),
            .edge_nxt (edge_nxt[g])
        );
    end

    // Built from next-state so it lines up with the registered RISE/FALL.
    always_ff @(posedge PCLK) begin
        if (PRESET) ANY_EDGE <= 1'b0;
        else        ANY_EDGE <= |edge_nxt;
    end
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed table-driven bench: each row holds inputs for N cycles, then checks
// outputs (after every cycle when 'every' is set, else only after the last).

module tb_gpio_in_debounce;
    logic       PCLK;
    logic       PRESET;
    logic [7:0] PIN_IN;
    logic [7:0] BYPASS;
    logic [7:0] GPIO_IN;
    logic [7:0] RISE;
    logic [7:0] FALL;
    logic       ANY_EDGE;

    int checks = 0;
    int errors = 0;

    gpio_in_debounce #(
        .IO_NUM      (8),
        .SYNC_STAGES (2),
        .TICK_DIV    (4),
        .DB_COUNT    (3),
        .RESET_VAL   (32'h0)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PIN_IN   (PIN_IN),
        .BYPASS   (BYPASS),
        .GPIO_IN  (GPIO_IN),
        .RISE     (RISE),
        .FALL     (FALL),
        .ANY_EDGE (ANY_EDGE)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] pin;
        logic [7:0] byp;
        int         n;
        bit         every;
        logic [7:0] gpio;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic rst, input logic [7:0] pin,
                       input logic [7:0] byp, input int n, input bit every,
                       input logic [7:0] gpio, input logic [7:0] rise,
                       input logic [7:0] fall, input logic any);
        vec_t v;
        v.name = name; v.rst = rst; v.pin = pin; v.byp = byp; v.n = n;
        v.every = every; v.gpio = gpio; v.rise = rise; v.fall = fall; v.any = any;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input string fld, input int cyc,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s cycle %0d: got %h expected %h", nm, fld, cyc, act, exp);
        end
    endtask

    initial begin
        PRESET = 1'b1;
        PIN_IN = 8'h00;
        BYPASS = 8'h00;

        // Reset with pins high; all bits accepted on the 3rd tick (edge 12).
        add("rstA",    1, 8'hFF, 8'h00,  3, 1, 8'h00, 8'h00, 8'h00, 0);
        add("relA",    0, 8'hFF, 8'h00, 11, 1, 8'h00, 8'h00, 8'h00, 0);
        add("riseA",   0, 8'hFF, 8'h00,  1, 0, 8'hFF, 8'hFF, 8'h00, 1);
        add("holdA",   0, 8'hFF, 8'h00,  1, 0, 8'hFF, 8'h00, 8'h00, 0);
        // Reset from an all-ones level must not produce FALL.
        add("rstB",    1, 8'h00, 8'h00,  3, 1, 8'h00, 8'h00, 8'h00, 0);
        // Clean step on bit 0.
        add("relB",    0, 8'h01, 8'h00, 11, 1, 8'h00, 8'h00, 8'h00, 0);
        add("step",    0, 8'h01, 8'h00,  1, 0, 8'h01, 8'h01, 8'h00, 1);
        add("stepH",   0, 8'h01, 8'h00,  1, 0, 8'h01, 8'h00, 8'h00, 0);
        // Glitch on bit 1: 6 cycles high, then low; never accepted.
        add("glitchH", 0, 8'h03, 8'h00,  6, 1, 8'h01, 8'h00, 8'h00, 0);
        add("glitchL", 0, 8'h01, 8'h00, 11, 1, 8'h01, 8'h00, 8'h00, 0);
        // Bit 1 again: needs a full 3 ticks (edges 36,40,44), so count was cleared.
        add("b1wait",  0, 8'h03, 8'h00, 13, 1, 8'h01, 8'h00, 8'h00, 0);
        add("b1acc",   0, 8'h03, 8'h00,  1, 0, 8'h03, 8'h02, 8'h00, 1);
        add("b1hold",  0, 8'h03, 8'h00,  1, 0, 8'h03, 8'h00, 8'h00, 0);
        // First differing sample lands on a tick edge (48,52,56).
        add("b2wait",  0, 8'h07, 8'h00, 10, 1, 8'h03, 8'h00, 8'h00, 0);
        add("b2acc",   0, 8'h07, 8'h00,  1, 0, 8'h07, 8'h04, 8'h00, 1);
        add("b2hold",  0, 8'h07, 8'h00,  1, 0, 8'h07, 8'h00, 8'h00, 0);
        // Simultaneous: bit 2 falls, bit 3 rises.
        add("simWait", 0, 8'h0B, 8'h00, 10, 1, 8'h07, 8'h00, 8'h00, 0);
        add("sim",     0, 8'h0B, 8'h00,  1, 0, 8'h0B, 8'h08, 8'h04, 1);
        add("simHold", 0, 8'h0B, 8'h00,  1, 0, 8'h0B, 8'h00, 8'h00, 0);
        // Bypass on bit 5: 3-cycle latency, pin toggles every 5 cycles.
        add("rstC",    1, 8'h00, 8'h20,  2, 1, 8'h00, 8'h00, 8'h00, 0);
        add("byR0",    0, 8'h20, 8'h20,  2, 1, 8'h00, 8'h00, 8'h00, 0);
        add("byR1",    0, 8'h20, 8'h20,  1, 0, 8'h20, 8'h20, 8'h00, 1);
        add("byRh",    0, 8'h20, 8'h20,  2, 1, 8'h20, 8'h00, 8'h00, 0);
        add("byF0",    0, 8'h00, 8'h20,  2, 1, 8'h20, 8'h00, 8'h00, 0);
        add("byF1",    0, 8'h00, 8'h20,  1, 0, 8'h00, 8'h00, 8'h20, 1);
        add("byFh",    0, 8'h00, 8'h20,  2, 1, 8'h00, 8'h00, 8'h00, 0);
        add("byR2",    0, 8'h20, 8'h20,  2, 1, 8'h00, 8'h00, 8'h00, 0);
        add("byR3",    0, 8'h20, 8'h20,  1, 0, 8'h20, 8'h20, 8'h00, 1);
        add("byR3h",   0, 8'h20, 8'h20,  2, 1, 8'h20, 8'h00, 8'h00, 0);
        // Reset mid-count on bit 4 after 2 ticks; full 3 ticks needed afterwards.
        add("rstD",    1, 8'h00, 8'h00,  2, 1, 8'h00, 8'h00, 8'h00, 0);
        add("midCnt",  0, 8'h10, 8'h00,  9, 1, 8'h00, 8'h00, 8'h00, 0);
        add("midRst",  1, 8'h10, 8'h00,  1, 0, 8'h00, 8'h00, 8'h00, 0);
        add("reRel",   0, 8'h10, 8'h00, 11, 1, 8'h00, 8'h00, 8'h00, 0);
        add("reAcc",   0, 8'h10, 8'h00,  1, 0, 8'h10, 8'h10, 8'h00, 1);
        add("reHold",  0, 8'h10, 8'h00,  1, 0, 8'h10, 8'h00, 8'h00, 0);

        foreach (tbl[r]) begin
            PRESET = tbl[r].rst;
            PIN_IN = tbl[r].pin;
            BYPASS = tbl[r].byp;
            for (int c = 0; c < tbl[r].n; c++) begin
                @(posedge PCLK);
                #1;
                if (tbl[r].every || c == tbl[r].n - 1) begin
                    chk(tbl[r].name, "gpio", c, GPIO_IN, tbl[r].gpio);
                    chk(tbl[r].name, "rise", c, RISE, tbl[r].rise);
                    chk(tbl[r].name, "fall", c, FALL, tbl[r].fall);
                    chk(tbl[r].name, "any",  c, {7'd0, ANY_EDGE}, {7'd0, tbl[r].any});
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
